alu_exec_unit: RTL

Multi-cycle execution unit that consumes the 4-bit ALUControl code produced by the control unit's ALU decoder and computes the result. It sits between the decode and writeback stages. Operands and a control code are accepted over a valid/ready handshake, and a held result plus Zero flag is returned over a valid/ready handshake. Logic ops take one cycle; shifts iterate one bit per cycle unless the barrel-shifter option is compiled in.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_shift_iter.sv | 45 ++++
 rtl/alu_exec_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes, FSM state encoding and widths for the execution unit.
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLTB = 4'b1000,
    ALU_XOR  = 4'b1001
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input logic [ALU_CTRL_W-1:0] c);
    return (c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// One-bit-per-cycle shifter: loads operand and amount, shifts until the counter empties.
// o_done flags the cycle whose shift (o_next) is the final one.
module alu_shift_iter #(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_load,
  input  logic                     i_left,
  input  logic                     i_arith,
  input  logic [WIDTH-1:0]         i_data,
  input  logic [$clog2(WIDTH)-1:0] i_amt,
  output logic [WIDTH-1:0]         o_next,
  output logic                     o_done
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  logic             r_left;
  logic             r_arith;

  assign o_next = r_left ? {r_work[WIDTH-2:0], 1'b0}
                         : {r_arith & r_work[WIDTH-1], r_work[WIDTH-1:1]};
  assign o_done = (r_cnt == SHW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work  <= '0;
      r_cnt   <= '0;
      r_left  <= 1'b0;
      r_arith <= 1'b0;
    end else if (i_load) begin
      r_work  <= i_data;
      r_cnt   <= i_amt;
      r_left  <= i_left;
      r_arith <= i_arith;
    end else if (r_cnt != '0) begin
      r_work <= o_next;
      r_cnt  <= r_cnt - SHW'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit with valid/ready in and out and a held result.
// Define ALU_FAST_SHIFT_EN for a single-cycle barrel shifter instead of the iterative one.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]      src_a,
  input  logic [WIDTH-1:0]      src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      result,
  output logic                  zero,
  output logic                  illegal
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       r_state, w_next_state;
  logic [WIDTH-1:0] r_result, w_alu;
  logic             r_illegal, w_illegal;
  logic [SHW-1:0]   w_amt;
  logic             w_accept;

  assign w_amt    = src_b[SHW-1:0];
  assign w_accept = (r_state == ST_IDLE) && in_valid;

  always_comb begin
    w_alu     = '0;
    w_illegal = 1'b0;
    case (alu_control)
      ALU_ADD:           w_alu = src_a + src_b;
      ALU_SUB:           w_alu = src_a - src_b;
      ALU_AND:           w_alu = src_a & src_b;
      ALU_OR:            w_alu = src_a | src_b;
      ALU_XOR:           w_alu = src_a ^ src_b;
      ALU_SLT, ALU_SLTB: w_alu = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
`ifdef ALU_FAST_SHIFT_EN
      ALU_SLL:           w_alu = src_a << w_amt;
      ALU_SRL:           w_alu = src_a >> w_amt;
      ALU_SRA:           w_alu = $signed(src_a) >>> w_amt;
`else
      // Only the zero-amount case lands here; nonzero amounts finish in the iterator.
      ALU_SLL, ALU_SRL, ALU_SRA: w_alu = src_a;
`endif
      default:           w_illegal = 1'b1;
    endcase
  end

`ifndef ALU_FAST_SHIFT_EN
  logic             w_iter;
  logic [WIDTH-1:0] w_sh_next;
  logic             w_sh_done;

  assign w_iter = is_shift_op(alu_control) && (w_amt != '0);

  alu_shift_iter #(.WIDTH(WIDTH)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept && w_iter),
    .i_left  (alu_control == ALU_SLL),
    .i_arith (alu_control == ALU_SRA),
    .i_data  (src_a),
    .i_amt   (w_amt),
    .o_next  (w_sh_next),
    .o_done  (w_sh_done)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next_state = ST_DONE;
`ifndef ALU_FAST_SHIFT_EN
          if (w_iter) w_next_state = ST_SHIFT;
`endif
        end
      end
      ST_SHIFT: begin
`ifndef ALU_FAST_SHIFT_EN
        if (w_sh_done) w_next_state = ST_DONE;
`else
        w_next_state = ST_IDLE;
`endif
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_result  <= w_alu;
      r_illegal <= w_illegal;
    end
`ifndef ALU_FAST_SHIFT_EN
    else if ((r_state == ST_SHIFT) && w_sh_done) begin
      r_result <= w_sh_next;
    end
`endif
  end

  assign result  = r_result;
  assign zero    = (r_result == '0);
  assign illegal = r_illegal;

endmodule
